// File: rtl/axi_err_slv_flat.sv
// axi_err_slv_flat: AXI4 error slave with flattened channel ports; every burst is answered with an error.
// Optional macro AXI_ERR_SLV_FLAT_ATOP_EN: atomics with read response (aw_atop_i[5]) also return an R burst.

module axi_err_slv_flat_fifo #(
   parameter int unsigned Width = 1,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(Depth));
   assign data_o  = mem_q[rd_ptr_q];
   // a full FIFO refuses the push even if it is popped in the same cycle
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

module axi_err_slv_flat #(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned MaxWrTxns = 2,
   parameter int unsigned MaxRdTxns = 2,
   parameter logic [1:0]  WrResp    = 2'b11,
   parameter logic [1:0]  RdResp    = 2'b11,
   parameter logic [63:0] RespData  = 64'hca11ab1ebadcab1e,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic [7:0]           aw_len_i,
   input  logic [5:0]           aw_atop_i,
   input  logic                 w_valid_i,
   output logic                 w_ready_o,
   input  logic                 w_last_i,
   output logic                 b_valid_o,
   input  logic                 b_ready_i,
   output logic [IdWidth-1:0]   b_id_o,
   output logic [1:0]           b_resp_o,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [7:0]           ar_len_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_last_o,
   input  logic                 cnt_clr_i,
   output logic [CntWidth-1:0]  err_wr_cnt_o,
   output logic [CntWidth-1:0]  err_rd_cnt_o
);
   localparam int unsigned RdW = IdWidth + 8;

   typedef enum logic [0:0] {RIdle, RBurst} r_state_e;

   logic               aw_empty, aw_full, aw_hs;
   logic [IdWidth-1:0] aw_head;
   logic               w_last_hs;
   logic               b_empty, b_full, b_hs;
   logic               ar_hs, r_empty, r_full, r_push, r_pop;
   logic [RdW-1:0]     r_wdata, r_head;
   r_state_e           r_state_q, r_state_d;
   logic [7:0]         beat_cnt_q, beat_cnt_d;
   logic               rd_done;

`ifdef AXI_ERR_SLV_FLAT_ATOP_EN
   logic aw_atop_rd;
   logic unused_atop;
   assign unused_atop = ^aw_atop_i[4:0];
   assign aw_atop_rd  = aw_atop_i[5];
   assign aw_ready_o  = !aw_full && !(aw_atop_rd && r_full);
   assign aw_hs       = aw_valid_i && aw_ready_o;
   // an accepted atomic owns the R FIFO write port this cycle
   assign ar_ready_o  = !r_full && !(aw_valid_i && aw_atop_rd && aw_ready_o);
   assign ar_hs       = ar_valid_i && ar_ready_o;
   assign r_push      = ar_hs || (aw_hs && aw_atop_rd);
   assign r_wdata     = (aw_hs && aw_atop_rd) ? {aw_id_i, aw_len_i} : {ar_id_i, ar_len_i};
`else
   logic unused_aw;
   assign unused_aw   = ^{aw_atop_i, aw_len_i};
   assign aw_ready_o  = !aw_full;
   assign aw_hs       = aw_valid_i && aw_ready_o;
   assign ar_ready_o  = !r_full;
   assign ar_hs       = ar_valid_i && ar_ready_o;
   assign r_push      = ar_hs;
   assign r_wdata     = {ar_id_i, ar_len_i};
`endif

   axi_err_slv_flat_fifo #(.Width(IdWidth), .Depth(MaxWrTxns)) i_aw_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (aw_hs),
      .data_i  (aw_id_i),
      .pop_i   (w_last_hs),
      .data_o  (aw_head),
      .empty_o (aw_empty),
      .full_o  (aw_full)
   );

   assign w_ready_o = !aw_empty && !b_full;
   assign w_last_hs = w_valid_i && w_ready_o && w_last_i;

   axi_err_slv_flat_fifo #(.Width(IdWidth), .Depth(2)) i_b_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_last_hs),
      .data_i  (aw_head),
      .pop_i   (b_hs),
      .data_o  (b_id_o),
      .empty_o (b_empty),
      .full_o  (b_full)
   );

   assign b_valid_o = !b_empty;
   assign b_resp_o  = WrResp;
   assign b_hs      = b_valid_o && b_ready_i;

   axi_err_slv_flat_fifo #(.Width(RdW), .Depth(MaxRdTxns)) i_r_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (r_push),
      .data_i  (r_wdata),
      .pop_i   (r_pop),
      .data_o  (r_head),
      .empty_o (r_empty),
      .full_o  (r_full)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state_q  <= RIdle;
         beat_cnt_q <= '0;
      end else begin
         r_state_q  <= r_state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      r_state_d  = r_state_q;
      beat_cnt_d = beat_cnt_q;
      r_valid_o  = 1'b0;
      r_last_o   = 1'b0;
      r_pop      = 1'b0;
      case (r_state_q)
         RIdle: begin
            if (!r_empty) begin
               beat_cnt_d = r_head[7:0];
               r_state_d  = RBurst;
            end
         end
         RBurst: begin
            r_valid_o = 1'b1;
            r_last_o  = (beat_cnt_q == '0);
            if (r_ready_i) begin
               if (beat_cnt_q == '0) begin
                  r_pop     = 1'b1;
                  r_state_d = RIdle;
               end else begin
                  beat_cnt_d = beat_cnt_q - 1'b1;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   assign r_id_o   = r_head[RdW-1:8];
   assign r_resp_o = RdResp;
   assign rd_done  = r_valid_o && r_ready_i && r_last_o;

   for (genvar g = 0; g < DataWidth; g++) begin : g_pattern
      assign r_data_o[g] = RespData[g % 64];
   end

   // clear takes priority over a coincident increment
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_wr_cnt_o <= '0;
         err_rd_cnt_o <= '0;
      end else if (cnt_clr_i) begin
         err_wr_cnt_o <= '0;
         err_rd_cnt_o <= '0;
      end else begin
         if (b_hs && (err_wr_cnt_o != '1))    err_wr_cnt_o <= err_wr_cnt_o + 1'b1;
         if (rd_done && (err_rd_cnt_o != '1)) err_rd_cnt_o <= err_rd_cnt_o + 1'b1;
      end
   end
endmodule

// File: tb/tb_axi_err_slv_flat.sv
// Self-checking bench for axi_err_slv_flat: directed scenarios plus randomized traffic against a queue model.
module tb_axi_err_slv_flat;
   localparam int unsigned IdW = 4;
   localparam int unsigned DW  = 64;
   localparam int unsigned CW  = 2;
   localparam logic [63:0] PAT  = 64'hca11ab1ebadcab1e;
   localparam logic [1:0]  RESP = 2'b11;

   typedef struct {
      logic [IdW-1:0] id;
      logic           last;
   } rbeat_t;

   logic clk = 1'b0;
   logic rst_n;
   logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
   logic ar_valid, ar_ready, r_valid, r_ready, r_last, cnt_clr;
   logic [IdW-1:0] aw_id, b_id, ar_id, r_id;
   logic [7:0] aw_len, ar_len;
   logic [5:0] aw_atop;
   logic [1:0] b_resp, r_resp;
   logic [DW-1:0] r_data;
   logic [CW-1:0] err_wr_cnt, err_rd_cnt;

   int checks = 0;
   int passes = 0;
   int model_wr = 0;
   int model_rd = 0;
   rbeat_t exp_r[$];
   logic [IdW-1:0] exp_b[$];

   always #5 clk = ~clk;

   axi_err_slv_flat #(
      .IdWidth(IdW), .DataWidth(DW), .MaxWrTxns(2), .MaxRdTxns(2), .CntWidth(CW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_len_i(aw_len), .aw_atop_i(aw_atop),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
      .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
      .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
      .r_resp_o(r_resp), .r_last_o(r_last),
      .cnt_clr_i(cnt_clr), .err_wr_cnt_o(err_wr_cnt), .err_rd_cnt_o(err_rd_cnt)
   );

   function automatic int sat(int c);
      return (c >= (1 << CW) - 1) ? c : c + 1;
   endfunction

   task automatic idle_inputs();
      aw_valid = 0; aw_id = '0; aw_len = '0; aw_atop = '0;
      w_valid = 0; w_last = 0; b_ready = 0;
      ar_valid = 0; ar_id = '0; ar_len = '0; r_ready = 0; cnt_clr = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (aw_ready !== 1'b1) $display("FAIL reset_aw_ready: got %b want 1", aw_ready); else passes++;
      checks++; if (ar_ready !== 1'b1) $display("FAIL reset_ar_ready: got %b want 1", ar_ready); else passes++;
      checks++; if (w_ready !== 1'b0) $display("FAIL reset_w_ready: got %b want 0", w_ready); else passes++;
      checks++; if (b_valid !== 1'b0) $display("FAIL reset_b_valid: got %b want 0", b_valid); else passes++;
      checks++; if (r_valid !== 1'b0 || r_last !== 1'b0) $display("FAIL reset_r: got valid %b last %b want 0 0", r_valid, r_last); else passes++;
      checks++; if (err_wr_cnt !== '0 || err_rd_cnt !== '0) $display("FAIL reset_cnt: got %0d %0d want 0 0", err_wr_cnt, err_rd_cnt); else passes++;
      rst_n = 1;
      model_wr = 0; model_rd = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_write();
      idle_inputs();
      aw_valid = 1; aw_id = 4'd3; aw_len = 8'd0;
      @(posedge clk); #1;
      aw_valid = 0;
      checks++; if (w_ready !== 1'b1) $display("FAIL sw_w_ready: got %b want 1", w_ready); else passes++;
      w_valid = 1; w_last = 1;
      checks++; if (b_valid !== 1'b0) $display("FAIL sw_b_early: got %b want 0", b_valid); else passes++;
      @(posedge clk); #1;
      w_valid = 0; w_last = 0;
      checks++; if (b_valid !== 1'b1 || b_id !== 4'd3 || b_resp !== RESP)
         $display("FAIL sw_b: got valid %b id %0d resp %b want 1 3 11", b_valid, b_id, b_resp); else passes++;
      @(posedge clk); #1;
      checks++; if (b_valid !== 1'b1) $display("FAIL sw_b_hold: got %b want 1", b_valid); else passes++;
      b_ready = 1;
      @(posedge clk); #1;
      b_ready = 0;
      model_wr = sat(model_wr);
      checks++; if (b_valid !== 1'b0) $display("FAIL sw_b_pop: got %b want 0", b_valid); else passes++;
      checks++; if (err_wr_cnt !== CW'(model_wr)) $display("FAIL sw_cnt: got %0d want %0d", err_wr_cnt, model_wr); else passes++;
   endtask

   task automatic test_read_burst();
      idle_inputs();
      ar_valid = 1; ar_id = 4'd5; ar_len = 8'd3; r_ready = 1;
      @(posedge clk); #1;
      ar_valid = 0;
      checks++; if (r_valid !== 1'b0) $display("FAIL rb_latency: got r_valid %b want 0", r_valid); else passes++;
      @(posedge clk); #1;
      for (int unsigned b = 0; b < 4; b++) begin
         checks++; if (r_valid !== 1'b1 || r_id !== 4'd5)
            $display("FAIL rb_beat%0d: got valid %b id %0d want 1 5", b, r_valid, r_id); else passes++;
         checks++; if (r_data !== PAT || r_resp !== RESP)
            $display("FAIL rb_data%0d: got %h/%b want %h/11", b, r_data, r_resp, PAT); else passes++;
         checks++; if (r_last !== (b == 3))
            $display("FAIL rb_last%0d: got %b want %b", b, r_last, (b == 3)); else passes++;
         @(posedge clk); #1;
      end
      r_ready = 0;
      model_rd = sat(model_rd);
      checks++; if (r_valid !== 1'b0) $display("FAIL rb_end: got r_valid %b want 0", r_valid); else passes++;
      checks++; if (err_rd_cnt !== CW'(model_rd)) $display("FAIL rb_cnt: got %0d want %0d", err_rd_cnt, model_rd); else passes++;
   endtask

   task automatic test_backpressure();
      logic [IdW-1:0] got[$];
      int wsent = 2;
      idle_inputs();
      aw_valid = 1; aw_id = 4'd1;
      @(posedge clk); #1;
      aw_id = 4'd2;
      @(posedge clk); #1;
      aw_id = 4'd3;
      checks++; if (aw_ready !== 1'b0) $display("FAIL bp_aw_full: got %b want 0", aw_ready); else passes++;
      @(posedge clk); #1;
      checks++; if (aw_ready !== 1'b0) $display("FAIL bp_aw_full_hold: got %b want 0", aw_ready); else passes++;
      w_valid = 1; w_last = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      aw_valid = 0;
      checks++; if (w_ready !== 1'b0) $display("FAIL bp_w_stall: got %b want 0", w_ready); else passes++;
      checks++; if (b_valid !== 1'b1 || b_id !== 4'd1) $display("FAIL bp_b_head: got %b id %0d want 1 1", b_valid, b_id); else passes++;
      b_ready = 1;
      for (int c = 0; c < 30 && got.size() < 3; c++) begin
         @(negedge clk);
         if (b_valid && b_ready) got.push_back(b_id);
         if (w_valid && w_ready) wsent++;
         @(posedge clk); #1;
         if (wsent >= 3) begin w_valid = 0; w_last = 0; end
      end
      idle_inputs();
      checks++; if (got.size() != 3) $display("FAIL bp_b_count: got %0d want 3", got.size()); else passes++;
      for (int unsigned k = 0; k < got.size(); k++) begin
         checks++; if (got[k] !== IdW'(k + 1)) $display("FAIL bp_b_order%0d: got %0d want %0d", k, got[k], k + 1); else passes++;
         model_wr = sat(model_wr);
      end
      checks++; if (err_wr_cnt !== CW'(model_wr)) $display("FAIL bp_cnt: got %0d want %0d", err_wr_cnt, model_wr); else passes++;
   endtask

   task automatic test_random_reads();
      logic [IdW-1:0] ids[8];
      logic [7:0] lens[8];
      int unsigned total = 0;
      idle_inputs();
      exp_r.delete();
      for (int unsigned k = 0; k < 8; k++) begin
         ids[k] = IdW'($urandom);
         lens[k] = 8'($urandom_range(0, 5));
         total += lens[k] + 1;
      end
      fork
         begin : ar_drv
            bit hs;
            for (int unsigned k = 0; k < 8; k++) begin
               ar_valid = 1; ar_id = ids[k]; ar_len = lens[k];
               hs = 0;
               for (int c = 0; c < 300 && !hs; c++) begin
                  @(negedge clk);
                  if (ar_ready) begin
                     hs = 1;
                     for (int unsigned b = 0; b <= lens[k]; b++) exp_r.push_back('{ids[k], (b == lens[k])});
                  end
                  @(posedge clk); #1;
               end
               ar_valid = 0;
               if (!hs) begin checks++; $display("FAIL rr_ar_timeout: txn %0d got no ar_ready want 1", k); end
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
         end
         begin : r_mon
            rbeat_t e;
            int unsigned got_beats = 0;
            for (int c = 0; c < 3000 && got_beats < total; c++) begin
               r_ready = 1'($urandom);
               @(negedge clk);
               if (r_valid && r_ready) begin
                  got_beats++;
                  if (exp_r.size() == 0) begin
                     checks++; $display("FAIL rr_extra_beat: got id %0d want none", r_id);
                  end else begin
                     e = exp_r.pop_front();
                     checks++; if (r_id !== e.id) $display("FAIL rr_id: got %0d want %0d", r_id, e.id); else passes++;
                     checks++; if (r_last !== e.last) $display("FAIL rr_last: got %b want %b", r_last, e.last); else passes++;
                     checks++; if (r_data !== PAT) $display("FAIL rr_data: got %h want %h", r_data, PAT); else passes++;
                     checks++; if (r_resp !== RESP) $display("FAIL rr_resp: got %b want %b", r_resp, RESP); else passes++;
                     if (e.last) model_rd = sat(model_rd);
                  end
               end
               @(posedge clk); #1;
            end
            r_ready = 0;
            if (got_beats < total) begin checks++; $display("FAIL rr_timeout: got %0d beats want %0d", got_beats, total); end
         end
      join
      checks++; if (err_rd_cnt !== CW'(model_rd)) $display("FAIL rr_cnt: got %0d want %0d", err_rd_cnt, model_rd); else passes++;
   endtask

   task automatic test_random_writes();
      logic [IdW-1:0] ids[8];
      logic [7:0] lens[8];
      idle_inputs();
      exp_b.delete();
      for (int unsigned k = 0; k < 8; k++) begin
         ids[k] = IdW'($urandom);
         lens[k] = 8'($urandom_range(0, 3));
      end
      fork
         begin : aw_drv
            bit hs;
            for (int unsigned k = 0; k < 8; k++) begin
               aw_valid = 1; aw_id = ids[k]; aw_len = lens[k]; aw_atop = {1'b0, 5'($urandom)};
               hs = 0;
               for (int c = 0; c < 300 && !hs; c++) begin
                  @(negedge clk);
                  if (aw_ready) begin hs = 1; exp_b.push_back(ids[k]); end
                  @(posedge clk); #1;
               end
               aw_valid = 0; aw_atop = '0;
               if (!hs) begin checks++; $display("FAIL rw_aw_timeout: txn %0d got no aw_ready want 1", k); end
               repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            end
         end
         begin : w_drv
            bit hs;
            for (int unsigned k = 0; k < 8; k++) begin
               for (int unsigned b = 0; b <= lens[k]; b++) begin
                  w_valid = 1; w_last = (b == lens[k]);
                  hs = 0;
                  for (int c = 0; c < 300 && !hs; c++) begin
                     @(negedge clk);
                     if (w_ready) hs = 1;
                     @(posedge clk); #1;
                  end
                  w_valid = 0; w_last = 0;
                  if (!hs) begin checks++; $display("FAIL rw_w_timeout: txn %0d got no w_ready want 1", k); end
               end
            end
         end
         begin : b_mon
            logic [IdW-1:0] e;
            int unsigned got_b = 0;
            for (int c = 0; c < 3000 && got_b < 8; c++) begin
               b_ready = 1'($urandom);
               @(negedge clk);
               if (b_valid && b_ready) begin
                  got_b++;
                  if (exp_b.size() == 0) begin
                     checks++; $display("FAIL rw_extra_b: got id %0d want none", b_id);
                  end else begin
                     e = exp_b.pop_front();
                     checks++; if (b_id !== e) $display("FAIL rw_b_id: got %0d want %0d", b_id, e); else passes++;
                     checks++; if (b_resp !== RESP) $display("FAIL rw_b_resp: got %b want %b", b_resp, RESP); else passes++;
                     model_wr = sat(model_wr);
                  end
               end
               @(posedge clk); #1;
            end
            b_ready = 0;
            if (got_b < 8) begin checks++; $display("FAIL rw_timeout: got %0d B want 8", got_b); end
         end
      join
      checks++; if (err_wr_cnt !== CW'(model_wr)) $display("FAIL rw_cnt: got %0d want %0d", err_wr_cnt, model_wr); else passes++;
   endtask

   task automatic do_read(input logic [IdW-1:0] id, input logic [7:0] len, output bit saw_last);
      ar_valid = 1; ar_id = id; ar_len = len; r_ready = 1;
      @(posedge clk); #1;
      ar_valid = 0;
      saw_last = 0;
      for (int c = 0; c < 600 && !saw_last; c++) begin
         @(negedge clk);
         if (r_valid && r_last) saw_last = 1;
         @(posedge clk); #1;
      end
      r_ready = 0;
   endtask

   task automatic test_reset_mid_burst();
      bit seen = 0;
      idle_inputs();
      ar_valid = 1; ar_id = 4'd2; ar_len = 8'd7; r_ready = 1;
      @(posedge clk); #1;
      ar_valid = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (r_valid) seen = 1; else begin @(posedge clk); #1; end
      end
      checks++; if (!seen) $display("FAIL rst_burst_start: got no r_valid want 1"); else passes++;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 0;
      #1;
      checks++; if (r_valid !== 1'b0 || r_last !== 1'b0) $display("FAIL rst_mid_r: got %b %b want 0 0", r_valid, r_last); else passes++;
      checks++; if (err_wr_cnt !== '0 || err_rd_cnt !== '0) $display("FAIL rst_mid_cnt: got %0d %0d want 0 0", err_wr_cnt, err_rd_cnt); else passes++;
      checks++; if (ar_ready !== 1'b1) $display("FAIL rst_mid_ar_ready: got %b want 1", ar_ready); else passes++;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (r_valid !== 1'b0 || ar_ready !== 1'b1) $display("FAIL rst_hold: got %b %b want 0 1", r_valid, ar_ready); else passes++;
      rst_n = 1;
      r_ready = 0;
      model_wr = 0; model_rd = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      bit ok;
      idle_inputs();
      cnt_clr = 1;
      @(posedge clk); #1;
      cnt_clr = 0;
      model_rd = 0; model_wr = 0;
      checks++; if (err_rd_cnt !== '0) $display("FAIL sat_clr: got %0d want 0", err_rd_cnt); else passes++;
      for (int unsigned k = 0; k < 5; k++) begin
         do_read(IdW'(k), 8'($urandom_range(0, 2)), ok);
         if (ok) model_rd = sat(model_rd);
         checks++; if (err_rd_cnt !== CW'(model_rd)) $display("FAIL sat_rd%0d: got %0d want %0d", k, err_rd_cnt, model_rd); else passes++;
      end
      ar_valid = 1; ar_id = 4'd7; ar_len = 8'd1; r_ready = 1;
      @(posedge clk); #1;
      ar_valid = 0;
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (r_valid && r_last) begin ok = 1; cnt_clr = 1; end
         @(posedge clk); #1;
         cnt_clr = 0;
      end
      r_ready = 0;
      model_rd = 0;
      checks++; if (!ok || err_rd_cnt !== '0) $display("FAIL sat_clr_wins: got %0d (last seen %b) want 0", err_rd_cnt, ok); else passes++;
   endtask

`ifdef AXI_ERR_SLV_FLAT_ATOP_EN
   task automatic test_atop();
      logic [IdW-1:0] rid[$];
      logic rl[$];
      int nb = 0;
      bit wdone = 0;
      idle_inputs();
      aw_valid = 1; aw_id = 4'd6; aw_len = 8'd1; aw_atop = 6'b100000;
      ar_valid = 1; ar_id = 4'd9; ar_len = 8'd0;
      b_ready = 1; r_ready = 1;
      @(negedge clk);
      checks++; if (aw_ready !== 1'b1 || ar_ready !== 1'b0) $display("FAIL atop_prio: got aw %b ar %b want 1 0", aw_ready, ar_ready); else passes++;
      @(posedge clk); #1;
      aw_valid = 0; aw_atop = '0;
      @(negedge clk);
      checks++; if (ar_ready !== 1'b1) $display("FAIL atop_ar_release: got %b want 1", ar_ready); else passes++;
      @(posedge clk); #1;
      ar_valid = 0; w_valid = 1; w_last = 1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (w_valid && w_ready) wdone = 1;
         if (b_valid && b_ready) begin
            nb++;
            checks++; if (b_id !== 4'd6) $display("FAIL atop_b_id: got %0d want 6", b_id); else passes++;
         end
         if (r_valid && r_ready) begin rid.push_back(r_id); rl.push_back(r_last); end
         @(posedge clk); #1;
         if (wdone) begin w_valid = 0; w_last = 0; end
      end
      idle_inputs();
      checks++; if (nb != 1) $display("FAIL atop_b_count: got %0d want 1", nb); else passes++;
      checks++; if (rid.size() != 3) $display("FAIL atop_r_count: got %0d want 3", rid.size()); else passes++;
      if (rid.size() == 3) begin
         checks++; if (rid[0] !== 4'd6 || rl[0] !== 1'b0) $display("FAIL atop_r0: got %0d/%b want 6/0", rid[0], rl[0]); else passes++;
         checks++; if (rid[1] !== 4'd6 || rl[1] !== 1'b1) $display("FAIL atop_r1: got %0d/%b want 6/1", rid[1], rl[1]); else passes++;
         checks++; if (rid[2] !== 4'd9 || rl[2] !== 1'b1) $display("FAIL atop_r2: got %0d/%b want 9/1", rid[2], rl[2]); else passes++;
      end
   endtask
`endif

   initial begin
      #900000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_write();
      test_read_burst();
      test_backpressure();
      test_random_reads();
      test_random_writes();
      test_reset_mid_burst();
      test_saturation();
`ifdef AXI_ERR_SLV_FLAT_ATOP_EN
      test_atop();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
